// File: rtl/branch_check_multi.sv
// Multi-entry branch hit detector: compares the PC against programmable origins,
// registers the lowest-index hit and runs a per-entry loop counter for taken/not-taken.
module branch_check_multi #(
   parameter int PC_WIDTH    = 10,
   parameter int NUM_ENTRIES = 4,
   parameter int INDEX_WIDTH = 2,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [PC_WIDTH-1:0]    PC,
   input  logic                   cfg_we,
   input  logic [INDEX_WIDTH-1:0] cfg_index,
   input  logic [PC_WIDTH-1:0]    cfg_origin,
   input  logic [PC_WIDTH-1:0]    cfg_destination,
   input  logic [COUNT_WIDTH-1:0] cfg_count,
   input  logic                   cfg_enable,
   output logic                   hit,
   output logic                   taken,
   output logic [INDEX_WIDTH-1:0] hit_index,
   output logic [PC_WIDTH-1:0]    branch_destination
);

   logic [PC_WIDTH-1:0]    origin [NUM_ENTRIES];
   logic [PC_WIDTH-1:0]    dest   [NUM_ENTRIES];
   logic [COUNT_WIDTH-1:0] reload [NUM_ENTRIES];
   logic [COUNT_WIDTH-1:0] count  [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] en;

   logic                   any_match;
   logic [INDEX_WIDTH-1:0] win;
   logic [PC_WIDTH-1:0]    win_dest;
   logic [COUNT_WIDTH-1:0] win_count;
   logic [COUNT_WIDTH-1:0] win_reload;

   // Scan from the top down so the lowest matching index is the last to overwrite.
   always_comb begin
      any_match  = 1'b0;
      win        = '0;
      win_dest   = '0;
      win_count  = '0;
      win_reload = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (en[i] && (PC == origin[i])) begin
            any_match  = 1'b1;
            win        = INDEX_WIDTH'(i);
            win_dest   = dest[i];
            win_count  = count[i];
            win_reload = reload[i];
         end
      end
   end

   // A write to the winning entry takes precedence over its counter update.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            origin[i] <= '0;
            dest[i]   <= '0;
            reload[i] <= '0;
            count[i]  <= '0;
            en[i]     <= 1'b0;
         end
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (cfg_we && (cfg_index == INDEX_WIDTH'(i))) begin
               origin[i] <= cfg_origin;
               dest[i]   <= cfg_destination;
               reload[i] <= cfg_count;
               count[i]  <= cfg_count;
               en[i]     <= cfg_enable;
            end else if (any_match && (win == INDEX_WIDTH'(i))) begin
               if (win_count != '0) count[i] <= win_count - 1'b1;
               else                 count[i] <= win_reload;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hit                <= 1'b0;
         taken              <= 1'b0;
         hit_index          <= '0;
         branch_destination <= '0;
      end else begin
         hit                <= any_match;
         taken              <= any_match && (win_count != '0);
         hit_index          <= win;
         branch_destination <= win_dest;
      end
   end

endmodule

// File: tb/tb_branch_check_multi.sv
// Directed bench for branch_check_multi: a 4-entry instance plus a 3-entry instance
// sharing the same stimulus, used to show out-of-range writes are dropped.
module tb_branch_check_multi;

   logic       clock = 1'b0;
   logic       reset;
   logic [9:0] PC;
   logic       cfg_we;
   logic [1:0] cfg_index;
   logic [9:0] cfg_origin;
   logic [9:0] cfg_destination;
   logic [7:0] cfg_count;
   logic       cfg_enable;

   logic       hit, taken;
   logic [1:0] hit_index;
   logic [9:0] branch_destination;
   logic       hit3, taken3;
   logic [1:0] hit_index3;
   logic [9:0] branch_destination3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   branch_check_multi #(.PC_WIDTH(10), .NUM_ENTRIES(4), .INDEX_WIDTH(2), .COUNT_WIDTH(8)) u_dut (
      .clock(clock), .reset(reset), .PC(PC), .cfg_we(cfg_we), .cfg_index(cfg_index),
      .cfg_origin(cfg_origin), .cfg_destination(cfg_destination), .cfg_count(cfg_count),
      .cfg_enable(cfg_enable), .hit(hit), .taken(taken), .hit_index(hit_index),
      .branch_destination(branch_destination)
   );

   branch_check_multi #(.PC_WIDTH(10), .NUM_ENTRIES(3), .INDEX_WIDTH(2), .COUNT_WIDTH(8)) u_dut3 (
      .clock(clock), .reset(reset), .PC(PC), .cfg_we(cfg_we), .cfg_index(cfg_index),
      .cfg_origin(cfg_origin), .cfg_destination(cfg_destination), .cfg_count(cfg_count),
      .cfg_enable(cfg_enable), .hit(hit3), .taken(taken3), .hit_index(hit_index3),
      .branch_destination(branch_destination3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic h, input logic t,
                             input logic [1:0] idx, input logic [9:0] dst);
      check({tag, ".hit"},   32'(hit), 32'(h));
      check({tag, ".taken"}, 32'(taken), 32'(t));
      check({tag, ".index"}, 32'(hit_index), 32'(idx));
      check({tag, ".dest"},  32'(branch_destination), 32'(dst));
   endtask

   task automatic cycle(input logic [9:0] pc_v);
      PC = pc_v;
      @(posedge clock);
      #1;
   endtask

   task automatic set_cfg(input logic [1:0] idx, input logic [9:0] org, input logic [9:0] dst,
                          input logic [7:0] cnt, input logic en);
      cfg_we          = 1'b1;
      cfg_index       = idx;
      cfg_origin      = org;
      cfg_destination = dst;
      cfg_count       = cnt;
      cfg_enable      = en;
   endtask

   task automatic write_entry(input logic [1:0] idx, input logic [9:0] org, input logic [9:0] dst,
                              input logic [7:0] cnt, input logic en);
      set_cfg(idx, org, dst, cnt, en);
      cycle(10'h3F0);
      cfg_we = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      PC = '0; cfg_we = 1'b0; cfg_index = '0; cfg_origin = '0;
      cfg_destination = '0; cfg_count = '0; cfg_enable = 1'b0;
      #12;
      expect_out("reset", 1'b0, 1'b0, 2'd0, 10'h000);
      reset = 1'b0;

      // No entries enabled: nothing can hit anywhere in the PC space.
      for (int p = 0; p < 1024; p++) begin
         cycle(10'(p));
         check("sweep", 32'({hit, taken, hit_index, branch_destination}), 32'd0);
      end

      // Loop of R=2: taken, taken, fall-through, then re-armed.
      write_entry(2'd1, 10'h040, 10'h010, 8'd2, 1'b1);
      cycle(10'h040); expect_out("loop1", 1'b1, 1'b1, 2'd1, 10'h010);
      cycle(10'h040); expect_out("loop2", 1'b1, 1'b1, 2'd1, 10'h010);
      cycle(10'h040); expect_out("loop3", 1'b1, 1'b0, 2'd1, 10'h010);
      cycle(10'h040); expect_out("loop4", 1'b1, 1'b1, 2'd1, 10'h010);
      cycle(10'h041); expect_out("nomatch", 1'b0, 1'b0, 2'd0, 10'h000);

      // Priority: entry 0 wins; entry 2 keeps its full count.
      write_entry(2'd0, 10'h100, 10'h200, 8'd5, 1'b1);
      write_entry(2'd2, 10'h100, 10'h300, 8'd5, 1'b1);
      cycle(10'h100); expect_out("prio", 1'b1, 1'b1, 2'd0, 10'h200);
      write_entry(2'd0, 10'h100, 10'h200, 8'd5, 1'b0);
      for (int k = 0; k < 6; k++) begin
         cycle(10'h100);
         expect_out("e2run", 1'b1, (k < 5), 2'd2, 10'h300);
      end

      // Detect-only entry; the 3-entry build must drop the index-3 write.
      write_entry(2'd3, 10'h3FF, 10'h155, 8'd0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         cycle(10'h3FF);
         expect_out("r0", 1'b1, 1'b0, 2'd3, 10'h155);
         check("oob3", 32'({hit3, taken3, hit_index3, branch_destination3}), 32'd0);
      end
      cycle(10'h040);
      check("e3.hit", 32'({hit3, taken3, hit_index3, branch_destination3}),
            32'({1'b1, 1'b1, 2'd1, 10'h010}));

      // Write and hit on the same entry: old contents decide, write wins the counter.
      write_entry(2'd0, 10'h080, 10'h0AA, 8'd3, 1'b1);
      set_cfg(2'd0, 10'h080, 10'h0AA, 8'd7, 1'b1);
      cycle(10'h080);
      cfg_we = 1'b0;
      expect_out("wrhit", 1'b1, 1'b1, 2'd0, 10'h0AA);
      for (int k = 0; k < 8; k++) begin
         cycle(10'h080);
         expect_out("rearm", 1'b1, (k < 7), 2'd0, 10'h0AA);
      end
      for (int k = 0; k < 6; k++) begin
         cycle(10'h080);
         expect_out("mid", 1'b1, 1'b1, 2'd0, 10'h0AA);
      end

      // Async reset between edges with C=1 outstanding.
      #2;
      reset = 1'b1;
      #1;
      expect_out("areset", 1'b0, 1'b0, 2'd0, 10'h000);
      check("areset3", 32'({hit3, taken3, hit_index3, branch_destination3}), 32'd0);
      #2;
      reset = 1'b0;
      cycle(10'h080); expect_out("postrst", 1'b0, 1'b0, 2'd0, 10'h000);
      cycle(10'h040); expect_out("postrst2", 1'b0, 1'b0, 2'd0, 10'h000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_check_multi.md
Name: branch_check_multi

Overview:
- Multi-entry, counted successor to the single-origin branch hit detector.
- Holds NUM_ENTRIES programmable branch entries. Each entry has an origin, a destination, an enable and a loop counter.
- Every cycle the incoming PC is compared against all enabled origins. The lowest-index match is registered one cycle later as hit, index, destination and taken/not-taken.
- Sits between the PC generator and the next-PC mux. Entries are loaded by the configuration write port.

Parameters:
PC_WIDTH, 10, width of PC, origin and destination.
NUM_ENTRIES, 4, number of branch entries (≥1; need not be a power of two).
INDEX_WIDTH, 2, entry index width; must satisfy 2**INDEX_WIDTH ≥ NUM_ENTRIES.
COUNT_WIDTH, 8, width of per-entry loop count.

Ports:
clock  input  1  sole clock; all state on rising edge.
reset  input  1  asynchronous, active-high; clears all state immediately.
PC  input  PC_WIDTH  current program counter to check.
cfg_we  input  1  configuration write strobe.
cfg_index  input  INDEX_WIDTH  entry to write.
cfg_origin  input  PC_WIDTH  origin PC for the written entry.
cfg_destination  input  PC_WIDTH  branch target for the written entry.
cfg_count  input  COUNT_WIDTH  reload count R for the written entry.
cfg_enable  input  1  enable bit for the written entry.
hit  output  1  registered: PC of previous cycle matched an enabled origin.
taken  output  1  registered: the hit entry's branch is taken.
hit_index  output  INDEX_WIDTH  registered: winning entry index.
branch_destination  output  PC_WIDTH  registered: winning entry destination.

Behaviour:
Entry state:
- Each entry i holds origin[i], dest[i], R[i] (reload), C[i] (live count) and en[i].

Reset (async assert, any time including mid-loop):
- All en=0; origin, dest, R and C = 0.
- hit=0, taken=0, hit_index=0, branch_destination=0.
- After reset release, no hit is possible until an entry is written with cfg_enable=1.

Compare (cycle t, combinational, uses contents as of start of t):
- match[i] = en[i] & (PC == origin[i]), exact equality on all PC_WIDTH bits.
- Winner w = lowest i with match[i]=1. Priority is fixed lowest-index-first.

Registered outputs (at edge ending t, visible in t+1; latency exactly 1):
- Any match: hit=1, hit_index=w, branch_destination=dest[w], taken=(C[w]!=0).
- No match: hit=0, taken=0, hit_index=0, branch_destination=0.

Counter update (same edge, winner only; non-winning matching entries are untouched):
- If C[w]!=0: C[w] <= C[w]-1 (branch taken).
- If C[w]==0: C[w] <= R[w] (fall through, loop re-armed).
- Consequence: R=N gives N taken branches, then 1 fall-through, repeating. R=0 gives detect-only, never taken.
- C never wraps; a decrement only occurs from a nonzero value.
- The same PC presented on consecutive cycles counts once per cycle.

Configuration write (cfg_we=1 at edge ending t):
- origin, dest, R <= cfg_count, C <= cfg_count, en <= cfg_enable for entry cfg_index.
- The new contents are effective for compares in cycle t+1.
- A write with cfg_index ≥ NUM_ENTRIES is ignored with no state change.
- Write and winner on the same entry in the same cycle:
  - The compare and the registered outputs use the old contents.
  - The counter update is discarded; the write wins.
- A write to a different entry does not disturb the winner's counter update.
- Writing en=0 disables the entry from t+1 and preserves nothing.
- Rewriting an entry always reloads C=R.

Test Plan:
- Reset then PC sweeps 0..1023 with no writes -> hit=0 and taken=0 throughout; all outputs 0.
- Write entry 1 {origin=0x040, dest=0x010, R=2, en=1}; present PC=0x040 four times -> over cycles t+1..t+4, hit=1 every cycle, hit_index=1, destination=0x010, taken=1,1,0,1 (count reloads after the fall-through).
- Entries 0 and 2 both with origin=0x100, dest 0x200 and 0x300, R=5; PC=0x100 -> hit_index=0, destination=0x200; entry 2 C remains 5 (checked by later disabling entry 0 and observing taken for 5 hits).
- Entry 3 R=0, origin=0x3FF; PC=0x3FF -> hit=1, taken=0 on every occurrence. A write with cfg_index beyond NUM_ENTRIES (NUM_ENTRIES=3 build) -> no state change.
- Entry 0 armed (C=3); in one cycle present PC=origin and write entry 0 with R=7 -> that cycle's result is taken=1 from the old contents; the next 7 hits are taken, then 1 not taken.
- Assert reset mid-loop (C=1) asynchronously between edges -> outputs drop to 0 immediately. After release, PC=old origin gives hit=0.
